uart_rx_frame_check: RTL
========================

UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

Interface
REQ-001 Parameter DATA_W, default 9, is the maximum data bits per frame; legal range 5..9.
REQ-002 Parameter OS, default 16, is the number of i_baud ticks per bit; it SHALL be even and at least 4.
REQ-003 i_clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_baud  input  1  oversample tick, one i_clk wide.
REQ-006 i_rx_in  input  1  serial line, already synchronised to i_clk; idle level is 1.
REQ-007 i_data_len  input  $clog2(DATA_W+1)  data bits per frame, 5..DATA_W; values outside that range SHALL be treated as DATA_W.
REQ-008 i_parity_sel  input  3  parity mode: 0xx none, 100 even, 101 odd, 110 stick-0, 111 stick-1.
REQ-009 i_stop2  input  1  1 = two stop bits checked, 0 = one stop bit.
REQ-010 o_data  output  DATA_W  received data, LSB first, right-aligned, with unused MSBs zero.
REQ-011 o_valid  output  1  one-cycle pulse marking the end of a frame.
REQ-012 o_parity_err, o_frame_err, o_break  output  1 each  error flags for the frame.
REQ-013 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have these states: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-015 Bit counting:
- A tick counter SHALL count i_baud pulses and clear on every state change.
- A "sample" is the i_baud tick on which the tick counter equals OS-1, except in START.
REQ-016 IDLE -> START when i_rx_in = 0 is seen on an i_baud tick.
REQ-017 START: on the i_baud tick on which the tick counter equals OS/2-1:
- if i_rx_in = 0, go to DATA;
- if i_rx_in = 1, return to IDLE with no o_valid (false start).
REQ-018 DATA:
- Each sample SHALL shift i_rx_in into the data register LSB-first and XOR it into the running parity.
- After i_data_len samples, go to PARITY if i_parity_sel[2] = 1, otherwise go to STOP1.
REQ-019 On entry to START, the data register, running parity and all error accumulators SHALL clear.
REQ-020 Parity expected value:
- stick modes: i_parity_sel[0];
- otherwise: running parity XOR i_parity_sel[0].
REQ-021 PARITY sample: the parity error is set if i_rx_in differs from the expected value; the FSM then goes to STOP1.
REQ-022 STOP1 sample:
- i_rx_in = 0 sets the frame error.
- Go to STOP2 if i_stop2 = 1, otherwise end the frame.
REQ-023 STOP2 sample: i_rx_in = 0 sets the frame error, then end the frame.
REQ-024 Break is set when all of the following hold:
- every data sample was 0;
- the parity sample was 0, or parity is disabled;
- every stop sample was 0.
REQ-025 End of frame:
- In the next cycle, o_data and the three flags SHALL be registered and o_valid SHALL pulse for exactly 1 cycle.
- The FSM SHALL go to IDLE.
- If i_rx_in = 0 at the last stop sample, no new START is entered until i_rx_in has been 1 on at least one i_baud tick.
REQ-026 o_data and the flags SHALL hold their values until the next o_valid.
REQ-027 i_data_len, i_parity_sel and i_stop2 SHALL be captured on entry to START; changes during a frame SHALL not affect that frame.
REQ-028 Ticks arriving when i_baud = 0 SHALL have no effect; there is no internal timeout.

Reset
REQ-029 When i_rst_n = 0:
- the FSM SHALL go to IDLE;
- all counters and o_data SHALL be 0;
- o_valid, o_parity_err, o_frame_err, o_break and o_busy SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no o_valid.
REQ-031 After reset is released, the block SHALL wait for a 1 on i_rx_in before it can detect a start bit.

Verification
REQ-032 Frame 8-bit data 0xA5, even parity bit 0, one stop bit, OS = 16 -> o_valid 1 pulse, o_data = 0x0A5, all flags 0.
REQ-033 The same frame with the parity bit set to 1 -> o_parity_err = 1, o_frame_err = 0.
REQ-034 7-bit data, stick-1 mode, two stop bits, second stop bit = 0 -> o_frame_err = 1, o_parity_err = 0, o_data[8:7] = 0.
REQ-035 Line held at 0 for 12 bit times, 8N1 -> o_break = 1 and o_frame_err = 1; no second frame until the line returns to 1.
REQ-036 0 on i_rx_in for 4 ticks, then 1 -> no o_valid and o_busy returns to 0 at the START midpoint.
REQ-037 Reset asserted during DATA bit 3 -> all outputs 0 immediately; a following clean 9-bit odd-parity frame 0x1FF is received correctly.

Source files
------------

// File: rtl/uart_rx_frame_check.sv
`default_nettype none
// uart_rx_frame_check: oversampled UART receiver with configurable length/parity/stop
// and parity, framing and break detection.
module uart_rx_frame_check #(
    parameter int DATA_W = 9,
    parameter int OS     = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_baud,
    input  logic                           i_rx_in,
    input  logic [$clog2(DATA_W+1)-1:0]    i_data_len,
    input  logic [2:0]                     i_parity_sel,
    input  logic                           i_stop2,
    output logic [DATA_W-1:0]              o_data,
    output logic                           o_valid,
    output logic                           o_parity_err,
    output logic                           o_frame_err,
    output logic                           o_break,
    output logic                           o_busy
);

    localparam int LW = $clog2(DATA_W + 1);
    localparam int TW = $clog2(OS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OS - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t              state_q;
    logic [TW-1:0]       tick_q;
    logic [LW-1:0]       bit_q;
    logic [LW-1:0]       len_q;
    logic [2:0]          psel_q;
    logic                stop2_q;
    logic [DATA_W-1:0]   shreg_q;
    logic                par_q;
    logic                perr_q;
    logic                ferr_q;
    logic                ones_q;
    logic                armed_q;

    logic [LW-1:0]       w_len;
    logic                w_par_exp;
    logic                w_sample;
    logic                w_end;

    always_comb begin
        w_len = i_data_len;
        if (i_data_len < LW'(5) || i_data_len > LW'(DATA_W))
            w_len = LW'(DATA_W);
    end

    assign w_par_exp = psel_q[1] ? psel_q[0] : (par_q ^ psel_q[0]);
    assign w_sample  = i_baud && (tick_q == TICK_LAST);
    assign w_end     = w_sample && ((state_q == STOP1 && !stop2_q) || state_q == STOP2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            len_q        <= '0;
            psel_q       <= '0;
            stop2_q      <= 1'b0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            ones_q       <= 1'b0;
            armed_q      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_baud) begin
                if (i_rx_in)
                    armed_q <= 1'b1;
                tick_q <= tick_q + 1'b1;
                case (state_q)
                    IDLE: begin
                        tick_q <= '0;
                        if (!i_rx_in && armed_q) begin
                            state_q <= START;
                            o_busy  <= 1'b1;
                            shreg_q <= '0;
                            par_q   <= 1'b0;
                            perr_q  <= 1'b0;
                            ferr_q  <= 1'b0;
                            ones_q  <= 1'b0;
                            len_q   <= w_len;
                            psel_q  <= i_parity_sel;
                            stop2_q <= i_stop2;
                        end
                    end
                    START: begin
                        if (tick_q == TICK_MID) begin
                            tick_q <= '0;
                            bit_q  <= '0;
                            if (i_rx_in) begin
                                state_q <= IDLE;
                                o_busy  <= 1'b0;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (w_sample) begin
                            tick_q         <= '0;
                            shreg_q[bit_q] <= i_rx_in;
                            par_q          <= par_q ^ i_rx_in;
                            ones_q         <= ones_q | i_rx_in;
                            bit_q          <= bit_q + 1'b1;
                            if (bit_q == len_q - 1'b1)
                                state_q <= psel_q[2] ? PARITY : STOP1;
                        end
                    end
                    PARITY: begin
                        if (w_sample) begin
                            tick_q  <= '0;
                            perr_q  <= (i_rx_in != w_par_exp);
                            ones_q  <= ones_q | i_rx_in;
                            state_q <= STOP1;
                        end
                    end
                    STOP1: begin
                        if (w_sample && stop2_q) begin
                            tick_q  <= '0;
                            ferr_q  <= ferr_q | ~i_rx_in;
                            ones_q  <= ones_q | i_rx_in;
                            state_q <= STOP2;
                        end
                    end
                    default: ;
                endcase

                // Last stop sample: publish results; a low line must go high before re-arming.
                if (w_end) begin
                    tick_q       <= '0;
                    state_q      <= IDLE;
                    o_busy       <= 1'b0;
                    o_valid      <= 1'b1;
                    o_data       <= shreg_q;
                    o_parity_err <= perr_q;
                    o_frame_err  <= ferr_q | ~i_rx_in;
                    o_break      <= ~(ones_q | i_rx_in);
                    armed_q      <= i_rx_in;
                end
            end
        end
    end

endmodule
`default_nettype wire
